// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V pipeline: ALU opcodes, forwarding selects
// and writeback source selects.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, signed set-less-than; any other
// opcode yields zero.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    logic lessThan;

    assign lessThan = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, lessThan};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, jump/branch resolution and the
// EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] writeData;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] jalrSum;
    logic            zero;

    // Select 11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        case (ForwardAE)
            FWD_WB:  srcA = ResultW;
            FWD_MEM: srcA = ALUResultM;
            default: srcA = RD1_E;
        endcase
    end

    always_comb begin
        case (ForwardBE)
            FWD_WB:  writeData = ResultW;
            FWD_MEM: writeData = ALUResultM;
            default: writeData = RD2_E;
        endcase
    end

    assign srcB = ALUSrcE ? ImmExtE : writeData;

    alu #(
        .XLEN(XLEN)
    ) uAlu (
        .SrcA      (srcA),
        .SrcB      (srcB),
        .ALUControl(ALUControlE),
        .ALUResult (aluResult),
        .Zero      (zero)
    );

    assign jalrSum   = srcA + ImmExtE;
    assign PCTargetE = jalrE ? {jalrSum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
    assign PCSrcE    = JumpE | jalrE | (BranchE & zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else begin
            ALUResultM <= aluResult;
            WriteDataM <= writeData;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized
// traffic compared against a behavioural model of the execute stage.
module tb_execute_cycle;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]      RdE;
    logic            RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]      RdM;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;

    int passCount  = 0;
    int checkCount = 0;

    // Model of the EX/MEM register contents.
    logic [XLEN-1:0] mAluM, mWdM, mPc4M;
    logic [4:0]      mRdM;
    logic            mRegWM, mMemWM;
    logic [1:0]      mResSrcM;

    execute_cycle #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RD1_E      (RD1_E),
        .RD2_E      (RD2_E),
        .ImmExtE    (ImmExtE),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .jalrE      (jalrE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .ALUControlE(ALUControlE),
        .ResultSrcE (ResultSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ResultW    (ResultW),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] refAlu(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] refFwd(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return mAluM;
        return rf;
    endfunction

    function automatic logic [XLEN-1:0] refSrcA();
        return refFwd(ForwardAE, RD1_E);
    endfunction

    function automatic logic [XLEN-1:0] refWd();
        return refFwd(ForwardBE, RD2_E);
    endfunction

    function automatic logic [XLEN-1:0] refResult();
        return refAlu(ALUControlE, refSrcA(), ALUSrcE ? ImmExtE : refWd());
    endfunction

    function automatic logic refPcSrc();
        return JumpE || jalrE || (BranchE && (refResult() == 32'd0));
    endfunction

    function automatic logic [XLEN-1:0] refTarget();
        logic [XLEN-1:0] t;
        if (jalrE) begin
            t = refSrcA() + ImmExtE;
            t[0] = 1'b0;
        end else begin
            t = PCE + ImmExtE;
        end
        return t;
    endfunction

    // Advance one clock and update the model as the EX/MEM register should.
    task automatic tick();
        logic [XLEN-1:0] r, wd;
        r  = refResult();
        wd = refWd();
        @(posedge clk);
        #1;
        if (rst_n) begin
            mAluM    = r;
            mWdM     = wd;
            mPc4M    = PCPlus4E;
            mRdM     = RdE;
            mRegWM   = RegWriteE;
            mMemWM   = MemWriteE;
            mResSrcM = ResultSrcE;
        end
    endtask

    task automatic clearInputs();
        {RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW} = '0;
        RdE = '0;
        {RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE} = '0;
        ALUControlE = '0;
        {ResultSrcE, ForwardAE, ForwardBE} = '0;
    endtask

    task automatic modelReset();
        {mAluM, mWdM, mPc4M} = '0;
        mRdM = '0;
        {mRegWM, mMemWM} = '0;
        mResSrcM = '0;
    endtask

    task automatic test_reset();
        logic [104:0] obs;
        clearInputs();
        RD1_E = 32'h55; RD2_E = 32'h66; RegWriteE = 1'b1; MemWriteE = 1'b1; RdE = 5'd9;
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        obs = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
        checkCount++;
        if (obs !== '0) $display("FAIL reset_state: got %h, want 0", obs);
        else passCount++;
        #2 rst_n = 1'b1;
        clearInputs();
    endtask

    task automatic test_add();
        clearInputs();
        RD1_E = 32'd5; RD2_E = 32'd7; RegWriteE = 1'b1; RdE = 5'd3;
        tick();
        checkCount++;
        if (ALUResultM !== 32'd12) $display("FAIL add_result: got %h, want 0000000c", ALUResultM);
        else passCount++;
        checkCount++;
        if (RdM !== 5'd3 || RegWriteM !== 1'b1)
            $display("FAIL add_ctrl: got rd=%0d rw=%b, want rd=3 rw=1", RdM, RegWriteM);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        clearInputs();
        RD1_E = 32'h8; RD2_E = 32'h8;
        tick();
        checkCount++;
        if (ALUResultM !== 32'h10) $display("FAIL b2b_first: got %h, want 00000010", ALUResultM);
        else passCount++;
        ForwardAE = 2'b10; ImmExtE = 32'd4; ALUSrcE = 1'b1;
        ForwardBE = 2'b01; ResultW = 32'd9; MemWriteE = 1'b1;
        RD1_E = 32'hDEAD; RD2_E = 32'hBEEF;
        tick();
        checkCount++;
        if (ALUResultM !== 32'h14) $display("FAIL b2b_fwd_mem: got %h, want 00000014", ALUResultM);
        else passCount++;
        checkCount++;
        if (WriteDataM !== 32'd9 || MemWriteM !== 1'b1)
            $display("FAIL b2b_fwd_wb: got wd=%h mw=%b, want wd=00000009 mw=1",
                     WriteDataM, MemWriteM);
        else passCount++;
    endtask

    task automatic test_branch();
        clearInputs();
        BranchE = 1'b1; ALUControlE = 3'b001;
        RD1_E = 32'h20; RD2_E = 32'h20; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        checkCount++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8)
            $display("FAIL beq_taken: got src=%b tgt=%h, want src=1 tgt=000000f8",
                     PCSrcE, PCTargetE);
        else passCount++;
        RD2_E = 32'h21;
        #1;
        checkCount++;
        if (PCSrcE !== 1'b0) $display("FAIL beq_not_taken: got src=%b, want 0", PCSrcE);
        else passCount++;
        tick();
    endtask

    task automatic test_jalr();
        clearInputs();
        jalrE = 1'b1; RD1_E = 32'h1003; ImmExtE = 32'd2; ALUSrcE = 1'b1;
        PCE = 32'h400; PCPlus4E = 32'h404; RegWriteE = 1'b1; ResultSrcE = 2'b10;
        #1;
        checkCount++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1004)
            $display("FAIL jalr_target: got src=%b tgt=%h, want src=1 tgt=00001004",
                     PCSrcE, PCTargetE);
        else passCount++;
        tick();
        checkCount++;
        if (PCPlus4M !== 32'h404 || ResultSrcM !== 2'b10)
            $display("FAIL jalr_link: got pc4=%h rs=%b, want pc4=00000404 rs=10",
                     PCPlus4M, ResultSrcM);
        else passCount++;
    endtask

    task automatic test_slt();
        clearInputs();
        ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
        tick();
        checkCount++;
        if (ALUResultM !== 32'd1) $display("FAIL slt_neg: got %h, want 00000001", ALUResultM);
        else passCount++;
        RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
        tick();
        checkCount++;
        if (ALUResultM !== 32'd0) $display("FAIL slt_swap: got %h, want 00000000", ALUResultM);
        else passCount++;
        ALUControlE = 3'b111; RD1_E = 32'h1234; RD2_E = 32'h77;
        tick();
        checkCount++;
        if (ALUResultM !== 32'd0) $display("FAIL alu_undef: got %h, want 00000000", ALUResultM);
        else passCount++;
    endtask

    task automatic test_random();
        logic [104:0] obs, exp;
        for (int i = 0; i < 300; i++) begin
            RD1_E = (i % 4 == 0) ? RD2_E : $urandom;
            RD2_E = (i % 5 == 0) ? RD1_E : $urandom;
            ImmExtE = $urandom; PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
            RdE = 5'($urandom); ALUControlE = 3'($urandom);
            ResultSrcE = 2'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            {RegWriteE, MemWriteE, ALUSrcE, BranchE} = 4'($urandom);
            JumpE = ($urandom_range(0, 7) == 0);
            jalrE = ($urandom_range(0, 5) == 0);
            #1;
            checkCount++;
            if (PCSrcE !== refPcSrc() || PCTargetE !== refTarget())
                $display("FAIL rand_redirect[%0d]: got src=%b tgt=%h, want src=%b tgt=%h",
                         i, PCSrcE, PCTargetE, refPcSrc(), refTarget());
            else passCount++;
            tick();
            obs = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
            exp = {mAluM, mWdM, mPc4M, mRdM, mRegWM, mMemWM, mResSrcM};
            checkCount++;
            if (obs !== exp) $display("FAIL rand_exmem[%0d]: got %h, want %h", i, obs, exp);
            else passCount++;
        end
    endtask

    task automatic test_async_reset();
        logic [104:0] obs, exp;
        clearInputs();
        RD1_E = 32'h40; RD2_E = 32'hABCD; ImmExtE = 32'h8; ALUSrcE = 1'b1;
        MemWriteE = 1'b1; RdE = 5'd7; PCPlus4E = 32'h50;
        tick();
        checkCount++;
        if (MemWriteM !== 1'b1 || WriteDataM !== 32'hABCD)
            $display("FAIL store_capture: got mw=%b wd=%h, want mw=1 wd=0000abcd",
                     MemWriteM, WriteDataM);
        else passCount++;
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        obs = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
        checkCount++;
        if (obs !== '0) $display("FAIL async_clear: got %h, want 0", obs);
        else passCount++;
        @(posedge clk);
        #1;
        obs = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
        checkCount++;
        if (obs !== '0) $display("FAIL reset_hold: got %h, want 0", obs);
        else passCount++;
        #2 rst_n = 1'b1;
        tick();
        obs = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
        exp = {mAluM, mWdM, mPc4M, mRdM, mRegWM, mMemWM, mResSrcM};
        checkCount++;
        if (obs !== exp || ALUResultM !== 32'h48)
            $display("FAIL reset_resume: got %h, want %h", obs, exp);
        else passCount++;
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_jalr();
        test_slt();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipeline. It consumes the ID/EX register contents produced by the decode stage, applies operand forwarding, runs the ALU, resolves jumps and branches back to fetch, and registers the results into the EX/MEM pipeline register for the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low; clears the EX/MEM register.
- RD1_E, RD2_E  in  XLEN each  register-file operands from ID/EX.
- ImmExtE, PCE, PCPlus4E  in  XLEN each  immediate, PC and PC+4 from ID/EX.
- RdE  in  5  destination register.
- RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  in  1 each  control bits from ID/EX.
- ALUControlE  in  3  ALU operation.
- ResultSrcE  in  2  writeback source select, passed through.
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback-stage result, used as a forwarding source.
- PCSrcE  out  1  redirect fetch this cycle.
- PCTargetE  out  XLEN  redirect address.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  EX/MEM register.
- RdM  out  5  EX/MEM register.
- RegWriteM, MemWriteM  out  1 each  EX/MEM register.
- ResultSrcM  out  2  EX/MEM register.

## Operation
- Forwarding mux A and mux B are identical.
  - 00 selects RD1_E / RD2_E.
  - 01 selects ResultW.
  - 10 selects the registered ALUResultM.
  - 11 behaves as 00.
- SrcA is forward mux A.
- WriteData is forward mux B.
- SrcB is ImmExtE when ALUSrcE=1, else WriteData.
- ALU operations, all XLEN-bit:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 101 signed set-less-than, result 0 or 1.
  - Every other code gives result 0.
- Add and sub wrap modulo 2^XLEN; no overflow flag.
- Zero flag is 1 iff the ALU result equals 0.
- PCSrcE = JumpE | jalrE | (BranchE & Zero).
- PCTargetE:
  - When jalrE=1: (SrcA + ImmExtE) with bit 0 forced to 0.
  - Otherwise: PCE + ImmExtE, modulo 2^XLEN.
- On each rising clk with rst_n high, EX/MEM captures:
  - ALUResultM ← ALU result.
  - WriteDataM ← WriteData.
  - RdM ← RdE.
  - PCPlus4M ← PCPlus4E.
  - RegWriteM, MemWriteM, ResultSrcM ← their E counterparts.
- Bubbles arrive as all-zero control from the ID/EX flush. They propagate with RegWriteM=0 and MemWriteM=0 and need no special handling.

## Timing
- EX/MEM latency: 1 cycle.
- PCSrcE and PCTargetE are combinational from the current ID/EX contents and forwarding inputs; they are valid in the same cycle.
- Forwarding select 10 is back-to-back forwarding: it uses the value registered at the previous edge.
- rst_n low clears every EX/MEM output to 0 immediately, independent of clk.
  - While rst_n stays low, the register holds 0.
  - The first capture occurs at the first rising clk after rst_n deasserts.
- Reset mid-stream discards the in-flight instruction. No store or register write escapes, since MemWriteM=RegWriteM=0.
- PCSrcE has no reset value of its own. It follows the inputs, which the upstream reset drives to 0.

## Structure
- Shared package riscv_pkg holds:
  - ALU opcode constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward select constants: FWD_RF, FWD_WB, FWD_MEM.
  - ResultSrc encodings.
- One sub-module, alu: combinational; inputs SrcA, SrcB, ALUControl; outputs ALUResult, Zero.
- Forwarding muxes, target adder and EX/MEM register stay in execute_cycle.

## Test plan
- add, no forwarding: RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000, RegWriteE=1, RdE=3 → next edge ALUResultM=12, RdM=3, RegWriteM=1.
- Back-to-back forward: cycle 1 produces ALUResultM=0x10; cycle 2 has ForwardAE=10, ImmExtE=4, ALUSrcE=1, op add → ALUResultM=0x14. With ForwardBE=01, ResultW=9 and MemWriteE=1 → WriteDataM=9.
- beq: BranchE=1, sub with equal operands 0x20, 0x20, PCE=0x100, ImmExtE=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0xF8. With unequal operands → PCSrcE=0.
- jalr: jalrE=1, SrcA=0x1003, ImmExtE=2 → PCTargetE=0x1004, PCSrcE=1, PCPlus4M=PCPlus4E after the edge.
- slt signed: SrcA=0xFFFFFFFF, SrcB=1, op 101 → ALUResultM=1. Swapped operands → 0. Undefined op 111 → 0.
- Async reset: drive a store (MemWriteE=1); assert rst_n low between edges → all EX/MEM outputs 0 immediately. Release → capture resumes at the next edge.
